// File: rtl/pcie_bar0_regs.sv
// pcie_bar0_regs: BAR0 CSR slave with ID, scratch, control/status, 64-bit counter and soft irq
// Define BAR0_ERR_LOG_EN to add the ERR_CNT register (unmapped-access counter) at offset 0x1C.
module pcie_bar0_regs #(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [31:0] ID_VALUE    = 32'hFE1C0001,
  parameter int          INIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  input  logic [3:0]            avs_byteenable,
  output logic [31:0]           avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  avs_waitrequest,
  output logic                  irq
);
  typedef enum logic {INIT, READY} state_t;
  state_t      state;
  logic [3:0]  init_cnt;
  logic [31:0] scratch, hi_latch, rdata, rd_d1, bemask;
  logic [63:0] cnt;
  logic [2:0]  a;
  logic        hi_a, acc_rd, acc_wr, irq_en, pending, rd_v1;
  logic        wr_scr, wr_ctl, w1c, trig, cnt_clr;
`ifdef BAR0_ERR_LOG_EN
  logic [15:0] err_cnt;
`endif
  assign a       = avs_address[2:0];
  assign hi_a    = |avs_address[ADDR_WIDTH-1:3];
  assign acc_wr  = avs_write & ~avs_waitrequest;
  assign acc_rd  = avs_read & ~avs_write & ~avs_waitrequest;
  assign bemask  = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}}, {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
  assign wr_scr  = acc_wr & ~hi_a & (a == 3'd1);
  assign wr_ctl  = acc_wr & ~hi_a & (a == 3'd2) & avs_byteenable[0];
  assign w1c     = acc_wr & ~hi_a & (a == 3'd3) & avs_byteenable[0] & avs_writedata[0];
  assign trig    = acc_wr & ~hi_a & (a == 3'd6);
  assign cnt_clr = wr_ctl & avs_writedata[1];
  // Read data is captured at accept, so a cnt_clr in the following cycle cannot disturb it
  always_comb begin
    rdata = 32'hDEADBEEF;
    if (!hi_a)
      case (a)
        3'd0:    rdata = ID_VALUE;
        3'd1:    rdata = scratch;
        3'd2:    rdata = {31'd0, irq_en};
        3'd3:    rdata = {31'd0, pending};
        3'd4:    rdata = cnt[31:0];
        3'd5:    rdata = hi_latch;
        3'd6:    rdata = 32'd0;
`ifdef BAR0_ERR_LOG_EN
        3'd7:    rdata = {16'd0, err_cnt};
`endif
        default: rdata = 32'hDEADBEEF;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state             <= INIT;
      init_cnt          <= '0;
      avs_waitrequest   <= 1'b1;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
      rd_v1             <= 1'b0;
      rd_d1             <= '0;
      scratch           <= '0;
      hi_latch          <= '0;
      cnt               <= '0;
      irq_en            <= 1'b0;
      pending           <= 1'b0;
      irq               <= 1'b0;
    end else begin
      if (state == INIT) begin
        init_cnt <= init_cnt + 4'd1;
        if (init_cnt == 4'(INIT_CYCLES - 1)) begin
          state           <= READY;
          avs_waitrequest <= 1'b0;
        end
      end else
        cnt <= cnt_clr ? 64'd0 : cnt + 64'd1;
      rd_v1             <= acc_rd;
      rd_d1             <= acc_rd ? rdata : 32'd0;
      avs_readdatavalid <= rd_v1;
      avs_readdata      <= rd_d1;
      if (acc_rd & ~hi_a & (a == 3'd4)) hi_latch <= cnt[63:32];
      if (wr_scr) scratch <= (scratch & ~bemask) | (avs_writedata & bemask);
      if (wr_ctl) irq_en <= avs_writedata[0];
      pending <= trig | (pending & ~w1c);
      irq     <= irq_en & pending;
    end
`ifdef BAR0_ERR_LOG_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_cnt <= '0;
    else if (acc_wr & ~hi_a & (a == 3'd7)) err_cnt <= '0;
    else if ((acc_rd | acc_wr) & hi_a & ~&err_cnt) err_cnt <= err_cnt + 16'd1;
`endif
endmodule
